// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter plus control matrix (opcode -> 12-bit control word, HLT).
// Latency: the ring advances on the falling edge of CLK; CON is combinational from T, OPCODE and CLR (zero cycles).
// Backpressure: none; a HLT opcode seen in T4 freezes the ring at T4 until CLR, and CON is held at NOP meanwhile.
module controller_sequencer (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  OPCODE,
  output logic [11:0] CON,
  output logic        HLT,
  output logic [5:0]  T
);

  // Control word bit order: {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
  localparam logic [11:0] CW_NOP     = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;  // Ep, Lm_n: PC -> MAR
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;  // Cp: increment PC
  localparam logic [11:0] CW_FETCH3  = 12'h263;  // CE_n, Li_n: RAM -> IR
  localparam logic [11:0] CW_ADDR    = 12'h1A3;  // Lm_n, Ei_n: IR operand -> MAR
  localparam logic [11:0] CW_LDA5    = 12'h2C3;  // CE_n, La_n: RAM -> A
  localparam logic [11:0] CW_LDB5    = 12'h2E1;  // CE_n, Lb_n: RAM -> B
  localparam logic [11:0] CW_ADD6    = 12'h3C7;  // Eu, La_n: A+B -> A
  localparam logic [11:0] CW_SUB6    = 12'h3CF;  // Su, Eu, La_n: A-B -> A
  localparam logic [11:0] CW_OUT4    = 12'h3F2;  // Ea, Lo_n: A -> output register

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_T3 = 6'b000100,
    S_T4 = 6'b001000,
    S_T5 = 6'b010000,
    S_T6 = 6'b100000
  } state_t;

  state_t state_q, state_d;
  logic   hlt_q, hlt_d;
  logic   halt_req;

  // A halt opcode only counts while T4 is the active state.
  assign halt_req = (state_q == S_T4) && (OPCODE == OP_HLT);

  // State and halt registers: advance on the falling edge so CON settles before the datapath's rising-edge load.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= S_T1;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hlt_q   <= hlt_d;
    end
  end

  // Next state: ring T1..T6 unless halted; a halt request in T4 sets the sticky flag and parks the ring at T4.
  always_comb begin
    state_d = state_q;
    hlt_d   = hlt_q;
    if (!hlt_q) begin
      if (halt_req) begin
        hlt_d   = 1'b1;
        state_d = S_T4;
      end else begin
        case (state_q)
          S_T1:    state_d = S_T2;
          S_T2:    state_d = S_T3;
          S_T3:    state_d = S_T4;
          S_T4:    state_d = S_T5;
          S_T5:    state_d = S_T6;
          S_T6:    state_d = S_T1;
          default: state_d = S_T1;
        endcase
      end
    end
  end

  // Control matrix: fetch words in T1-T3 regardless of opcode, execute words in T4-T6; NOP under reset or halt.
  always_comb begin
    CON = CW_NOP;
    if (!CLR && !hlt_q) begin
      case (state_q)
        S_T1: CON = CW_FETCH1;
        S_T2: CON = CW_FETCH2;
        S_T3: CON = CW_FETCH3;
        S_T4: begin
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB: CON = CW_ADDR;
            OP_OUT:                 CON = CW_OUT4;
            default:                CON = CW_NOP;
          endcase
        end
        S_T5: begin
          case (OPCODE)
            OP_LDA:         CON = CW_LDA5;
            OP_ADD, OP_SUB: CON = CW_LDB5;
            default:        CON = CW_NOP;
          endcase
        end
        S_T6: begin
          case (OPCODE)
            OP_ADD:  CON = CW_ADD6;
            OP_SUB:  CON = CW_SUB6;
            default: CON = CW_NOP;
          endcase
        end
        default: CON = CW_NOP;
      endcase
    end
  end

  assign HLT = hlt_q;
  assign T   = state_q;

endmodule
